// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - prescaled up/down wrap/saturate tick counter
//
// Purpose:
//   A single-clock prescaler raises an internal step once every DIV clocks
//   (DIV = CLK_HZ / TICK_HZ) while en is high. A WIDTH-bit counter moves one
//   place on each step, either up or down. At a bound it either wraps or
//   holds. A synchronous load takes priority over a step. No derived clocks
//   are used.
//
// Ports:
//   clock     in   1      system clock, rising edge
//   rst_btn   in   1      asynchronous active-low reset
//   en        in   1      prescaler run enable; 0 holds prescaler and counter
//   dir       in   1      1 = count up, 0 = count down (used on step edges)
//   sat       in   1      1 = saturate at bounds, 0 = wrap (used on step edges)
//   load      in   1      synchronous load strobe, highest priority
//   load_val  in   WIDTH  value taken by io_out when load=1
//   io_out    out  WIDTH  registered counter value
//   tick      out  1      registered one-cycle pulse on every step edge
//   tc        out  1      registered one-cycle pulse on a boundary step

module tick_counter #(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 4
) (
  input  logic             clock,
  input  logic             rst_btn,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] io_out,
  output logic             tick,
  output logic             tc
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  // Guarded so a bad DIV still elaborates far enough to report the error.
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);

  localparam logic [PW-1:0]    PRE_MAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  if (DIV < 2) begin : g_bad_div
    $error("tick_counter: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("tick_counter: WIDTH must be within 1..32");
  end

  logic [PW-1:0]    pre;
  logic             step;
  logic             at_bound;
  logic [WIDTH-1:0] next_val;

  // The step fires on the last prescale count; en=0 freezes it.
  always_comb begin
    step     = en && (pre == PRE_MAX);
    at_bound = dir ? (io_out == CNT_MAX) : (io_out == '0);
    next_val = io_out;
    if (at_bound) begin
      // Saturation keeps the bound value; wrap jumps to the opposite bound.
      if (!sat) begin
        next_val = dir ? '0 : CNT_MAX;
      end
    end else if (dir) begin
      next_val = io_out + 1'b1;
    end else begin
      next_val = io_out - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_btn) begin
    if (!rst_btn) begin
      pre    <= '0;
      io_out <= '0;
      tick   <= 1'b0;
      tc     <= 1'b0;
    end else if (load) begin
      // Load also restarts the prescale period and swallows a coincident step.
      pre    <= '0;
      io_out <= load_val;
      tick   <= 1'b0;
      tc     <= 1'b0;
    end else begin
      tick <= step;
      tc   <= step && at_bound;
      if (en) begin
        pre <= step ? '0 : pre + 1'b1;
      end
      if (step) begin
        io_out <= next_val;
      end
    end
  end

endmodule

// File: tb/tb_tick_counter.sv
// tb/tb_tick_counter.sv - scoreboard bench for tick_counter

module tb_tick_counter;

  localparam int DIV  = 8;
  localparam int MAXV = 15;

  logic       clock;
  logic       rst_btn;
  logic       en;
  logic       dir;
  logic       sat;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] io_out;
  logic       tick;
  logic       tc;

  tick_counter #(
    .CLK_HZ (8),
    .TICK_HZ(1),
    .WIDTH  (4)
  ) dut (
    .clock   (clock),
    .rst_btn (rst_btn),
    .en      (en),
    .dir     (dir),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
    .io_out  (io_out),
    .tick    (tick),
    .tc      (tc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  // Expected {io_out, tick, tc} after each rising edge.
  logic [5:0] sb_q[$];

  // Reference state: counter value, enabled cycles into the current period,
  // and last pulse values.
  int m_cnt   = 0;
  int m_phase = 0;
  bit m_tick  = 0;
  bit m_tc    = 0;

  task automatic model_reset();
    m_cnt   = 0;
    m_phase = 0;
    m_tick  = 0;
    m_tc    = 0;
  endtask

  // Applies one rising edge to the reference using the inputs the DUT saw.
  task automatic model_edge();
    bit stepped;
    int n;
    if (!rst_btn) begin
      model_reset();
    end else if (load) begin
      m_cnt   = int'(load_val);
      m_phase = 0;
      m_tick  = 0;
      m_tc    = 0;
    end else begin
      stepped = en && (m_phase == DIV - 1);
      if (en) m_phase = stepped ? 0 : m_phase + 1;
      m_tick = stepped;
      m_tc   = 0;
      if (stepped) begin
        n = dir ? m_cnt + 1 : m_cnt - 1;
        if (n < 0 || n > MAXV) begin
          m_tc = 1;
          n    = sat ? m_cnt : ((n < 0) ? MAXV : 0);
        end
        m_cnt = n;
      end
    end
  endtask

  task automatic drive(input logic e, input logic d, input logic s,
                       input logic l, input logic [3:0] lv, input int n);
    logic [3:0] c;
    for (int i = 0; i < n; i++) begin
      en       = e;
      dir      = d;
      sat      = s;
      load     = l;
      load_val = lv;
      @(posedge clock);
      model_edge();
      c = m_cnt[3:0];
      sb_q.push_back({c, m_tick, m_tc});
      #1;
    end
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest expectation.
  always @(negedge clock) begin
    logic [5:0] exp_v;
    if (sb_q.size() > 0) begin
      exp_v  = sb_q.pop_front();
      checks = checks + 1;
      if ({io_out, tick, tc} !== exp_v) begin
        failures = failures + 1;
        $display("FAIL sb t=%0t io_out/tick/tc got %h/%b/%b expected %h/%b/%b",
                 $time, io_out, tick, tc, exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_btn  = 1'b0;
    en       = 1'b0;
    dir      = 1'b1;
    sat      = 1'b0;
    load     = 1'b0;
    load_val = 4'h0;
    #1;

    // Reset state, then free run upward with wrap.
    drive(1, 1, 0, 0, 4'h0, 2);
    rst_btn = 1'b1;
    drive(1, 1, 0, 0, 4'h0, 20);

    // Up wrap from E through F to 0.
    drive(1, 1, 0, 1, 4'hE, 1);
    drive(1, 1, 0, 0, 4'h0, 20);

    // Down saturate at 0 with repeated tc pulses.
    drive(1, 0, 1, 1, 4'h1, 1);
    drive(1, 0, 1, 0, 4'h0, 40);

    // Load coinciding with a step cycle.
    drive(1, 1, 0, 1, 4'h0, 1);
    while (m_phase != DIV - 1) drive(1, 1, 0, 0, 4'h0, 1);
    drive(1, 1, 0, 1, 4'h7, 1);
    drive(1, 1, 0, 0, 4'h0, 10);

    // Enable pause part way through a period.
    while (m_phase != 5) drive(1, 1, 0, 0, 4'h0, 1);
    drive(0, 1, 0, 0, 4'h0, 20);
    drive(1, 1, 0, 0, 4'h0, 10);

    // Asynchronous reset mid-period at io_out=9.
    drive(1, 1, 0, 1, 4'h9, 1);
    drive(1, 1, 0, 0, 4'h0, 3);
    @(negedge clock);
    #1;
    rst_btn = 1'b0;
    model_reset();
    #1;
    checks = checks + 1;
    if ({io_out, tick, tc} !== 6'b0) begin
      failures = failures + 1;
      $display("FAIL async_reset io_out/tick/tc got %h/%b/%b expected 0/0/0",
               io_out, tick, tc);
    end
    drive(1, 1, 0, 0, 4'h0, 2);
    rst_btn = 1'b1;
    drive(1, 1, 0, 0, 4'h0, 12);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0,
            4'($urandom_range(0, 15)), 1);
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clock);
    #1;
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain pending=%0d expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
